bcd_down_timer: RTL and testbench
=================================

BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all state changes on rising edge.
REQ-002 SHALL have port RST, input, 1, reset, asynchronous, active-high.
REQ-003 SHALL have port CE, input, 1, count-enable tick, one CLK wide, e.g. 1 Hz strobe.
REQ-004 SHALL have port LOAD, input, 1, load PRESET_M/PRESET_S into counter.
REQ-005 SHALL have port START, input, 1, begin or resume countdown.
REQ-006 SHALL have port STOP, input, 1, pause countdown.
REQ-007 SHALL have port PRESET_M, input, 8, BCD minutes {tens,units}, legal 00-59.
REQ-008 SHALL have port PRESET_S, input, 8, BCD seconds {tens,units}, legal 00-59.
REQ-009 SHALL have port CNT_M, output, 8, current BCD minutes {m1,m0}.
REQ-010 SHALL have port CNT_S, output, 8, current BCD seconds {s1,s0}.
REQ-011 SHALL have port BUSY, output, 1, high while state RUN.
REQ-012 SHALL have port DONE, output, 1, registered one-cycle pulse on reaching 00:00.
REQ-013 SHALL have port BORROW, output, 1, combinational, high when state RUN, CE=1, and CNT_S=00 with CNT_M not 00 (minute decrement this edge).
REQ-014 SHALL have port ERR, output, 1, sticky flag for rejected illegal preset.

Function
REQ-015 SHALL implement states IDLE, RUN, PAUSE, EXPIRED.
REQ-016 SHALL apply control priority LOAD > STOP > START > CE-decrement within one cycle.
REQ-017 SHALL treat a preset as legal only if every units nibble <= 9 and every tens nibble <= 5.
REQ-018 SHALL, on LOAD with legal preset in any state, load counts, clear ERR, go to IDLE next edge.
REQ-019 SHALL, on LOAD with illegal preset, leave counts and state unchanged and set ERR=1.
REQ-020 SHALL, on START in IDLE or PAUSE with count != 00:00, enter RUN next edge.
REQ-021 SHALL ignore START when count = 00:00, in RUN, or in EXPIRED.
REQ-022 SHALL, on STOP in RUN, enter PAUSE without decrementing, even if CE=1 the same cycle.
REQ-023 SHALL decrement only in RUN on cycles with CE=1; CNT updates at the edge sampling CE (1-cycle latency).
REQ-024 SHALL decrement s0; s0=0 wraps to 9 and borrows from s1; s1=0 wraps to 5 and borrows from m0; m0=0 wraps to 9 and borrows from m1.
REQ-025 SHALL, when the decrement yields 00:00, enter EXPIRED and assert DONE for exactly the next cycle, aligned with CNT=00:00.
REQ-026 SHALL hold CNT at 00:00 in EXPIRED and never underflow; only LOAD or RST leaves EXPIRED.
REQ-027 SHALL ignore CE in IDLE, PAUSE, EXPIRED (counts hold).
REQ-028 SHALL accept LOAD during RUN, abandoning countdown with no DONE and no decrement that cycle.
REQ-029 SHALL never output a non-BCD digit or a tens digit > 5.
REQ-030 SHALL hold BUSY=1 exactly while state is RUN.

Reset
REQ-031 SHALL on RST=1, independent of CLK, force state IDLE, CNT_M=00, CNT_S=00, DONE=0, ERR=0, BUSY=0.
REQ-032 SHALL, after RST deasserts, respond to controls from the first rising CLK edge.
REQ-033 SHALL abandon any countdown on RST mid-run with no DONE pulse.

Verification
REQ-034 Load 00:03, START, three CE ticks -> CNT 00:02, 00:01, 00:00; DONE one cycle with 00:00; state EXPIRED; BUSY low.
REQ-035 Load 02:00, START, one CE -> CNT 01:59, BORROW=1 during that CE cycle; next CE -> 01:58, BORROW=0.
REQ-036 Load 10:00, START, CE and STOP same cycle -> CNT stays 10:00, PAUSE; START, CE -> 09:59.
REQ-037 Load PRESET_S=8'h6A -> ERR=1, CNT unchanged; then load 00:45 -> ERR=0, CNT 00:45.
REQ-038 Expire at 00:00, then START and CE pulses -> CNT held 00:00, no further DONE; LOAD 01:00 -> IDLE.
REQ-039 Load 59:59, START, RST mid-run asynchronously -> CNT 00:00, IDLE immediately, DONE never asserted.

Source files
------------

// File: rtl/bcd_down_timer.sv
// bcd_down_timer: MM:SS BCD countdown timer with load/start/stop control and expiry pulse
module bcd_down_timer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic       LOAD,
  input  logic       START,
  input  logic       STOP,
  input  logic [7:0] PRESET_M,
  input  logic [7:0] PRESET_S,
  output logic [7:0] CNT_M,
  output logic [7:0] CNT_S,
  output logic       BUSY,
  output logic       DONE,
  output logic       BORROW,
  output logic       ERR
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;
  state_t     r_state, w_state;
  logic [7:0] r_m, r_s, w_m, w_s, w_dec_m, w_dec_s;
  logic       r_done, r_err, w_done, w_err;
  logic       w_legal, w_zero, w_b0, w_b1, w_b2;
  assign w_legal = PRESET_M[7:4] <= 4'd5 && PRESET_M[3:0] <= 4'd9 &&
                   PRESET_S[7:4] <= 4'd5 && PRESET_S[3:0] <= 4'd9;
  assign w_zero  = {r_m, r_s} == 16'd0;
  assign w_b0    = r_s[3:0] == 4'd0;
  assign w_b1    = w_b0 && r_s[7:4] == 4'd0;
  assign w_b2    = w_b1 && r_m[3:0] == 4'd0;
  assign w_dec_s = {w_b0 ? (r_s[7:4] == 4'd0 ? 4'd5 : r_s[7:4] - 4'd1) : r_s[7:4],
                    w_b0 ? 4'd9 : r_s[3:0] - 4'd1};
  assign w_dec_m = {w_b2 ? r_m[7:4] - 4'd1 : r_m[7:4],
                    w_b1 ? (r_m[3:0] == 4'd0 ? 4'd9 : r_m[3:0] - 4'd1) : r_m[3:0]};
  assign CNT_M  = r_m;
  assign CNT_S  = r_s;
  assign BUSY   = r_state == RUN;
  assign DONE   = r_done;
  assign ERR    = r_err;
  assign BORROW = r_state == RUN && CE && r_s == 8'd0 && r_m != 8'd0;
  // Next state: LOAD beats STOP beats START beats a CE decrement
  always_comb begin
    w_state = r_state;
    w_m     = r_m;
    w_s     = r_s;
    w_err   = r_err;
    w_done  = 1'b0;
    if (LOAD) begin
      if (w_legal) begin
        w_m     = PRESET_M;
        w_s     = PRESET_S;
        w_err   = 1'b0;
        w_state = IDLE;
      end else
        w_err = 1'b1;
    end else if (STOP) begin
      if (r_state == RUN) w_state = PAUSE;
    end else if (START && (r_state == IDLE || r_state == PAUSE)) begin
      if (!w_zero) w_state = RUN;
    end else if (CE && r_state == RUN) begin
      w_m = w_dec_m;
      w_s = w_dec_s;
      if ({w_dec_m, w_dec_s} == 16'd0) begin
        w_state = EXPIRED;
        w_done  = 1'b1;
      end
    end
  end
  // State and count registers, cleared asynchronously
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_m     <= 8'd0;
      r_s     <= 8'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_m     <= w_m;
      r_s     <= w_s;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end
endmodule

// File: tb/tb_bcd_down_timer.sv
// tb_bcd_down_timer: directed and random checks of bcd_down_timer against a seconds-count model
module tb_bcd_down_timer;
  logic       CLK = 1'b0;
  logic       RST, CE, LOAD, START, STOP;
  logic [7:0] PRESET_M, PRESET_S, CNT_M, CNT_S;
  logic       BUSY, DONE, BORROW, ERR;
  int vectors = 0, miscompares = 0;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;
  int   m_state, m_secs;
  logic m_err, m_done;

  bcd_down_timer dut (.CLK(CLK), .RST(RST), .CE(CE), .LOAD(LOAD), .START(START), .STOP(STOP),
                      .PRESET_M(PRESET_M), .PRESET_S(PRESET_S), .CNT_M(CNT_M), .CNT_S(CNT_S),
                      .BUSY(BUSY), .DONE(DONE), .BORROW(BORROW), .ERR(ERR));

  always #5 CLK = ~CLK;

  function automatic logic [7:0] to_bcd(int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  function automatic int from_bcd(logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit legal(logic [7:0] b);
    return from_bcd(b) < 60 && to_bcd(from_bcd(b)) == b;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " CNT_M"}, CNT_M, to_bcd(m_secs / 60));
    chk({tag, " CNT_S"}, CNT_S, to_bcd(m_secs % 60));
    chk({tag, " BUSY"}, {7'd0, BUSY}, {7'd0, m_state == S_RUN});
    chk({tag, " DONE"}, {7'd0, DONE}, {7'd0, m_done});
    chk({tag, " ERR"}, {7'd0, ERR}, {7'd0, m_err});
  endtask

  task automatic model_step(input logic ce, ld, st, sp, input logic [7:0] pm, ps);
    m_done = 1'b0;
    if (ld) begin
      if (legal(pm) && legal(ps)) begin
        m_secs  = from_bcd(pm) * 60 + from_bcd(ps);
        m_err   = 1'b0;
        m_state = S_IDLE;
      end else
        m_err = 1'b1;
    end else if (sp) begin
      if (m_state == S_RUN) m_state = S_PAUSE;
    end else if (st && (m_state == S_IDLE || m_state == S_PAUSE)) begin
      if (m_secs != 0) m_state = S_RUN;
    end else if (ce && m_state == S_RUN) begin
      m_secs--;
      if (m_secs == 0) begin
        m_state = S_EXP;
        m_done  = 1'b1;
      end
    end
  endtask

  task automatic tick(input logic ce, ld, st, sp, input logic [7:0] pm, ps, input string tag);
    CE = ce; LOAD = ld; START = st; STOP = sp; PRESET_M = pm; PRESET_S = ps;
    #1;
    chk({tag, " BORROW"}, {7'd0, BORROW},
        {7'd0, m_state == S_RUN && ce && m_secs % 60 == 0 && m_secs >= 60});
    model_step(ce, ld, st, sp, pm, ps);
    @(posedge CLK);
    #1;
    check_outputs(tag);
    @(negedge CLK);
  endtask

  task automatic do_reset(input string tag);
    #2 RST = 1'b1;
    #1;
    m_state = S_IDLE; m_secs = 0; m_err = 1'b0; m_done = 1'b0;
    check_outputs(tag);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; CE = 0; LOAD = 0; START = 0; STOP = 0; PRESET_M = 0; PRESET_S = 0;
    m_state = S_IDLE; m_secs = 0; m_err = 1'b0; m_done = 1'b0;
    #1;
    check_outputs("reset");
    @(negedge CLK);
    RST = 1'b0;
    tick(0, 1, 0, 0, 8'h00, 8'h03, "ld0003");
    tick(0, 0, 1, 0, 8'h00, 8'h00, "start");
    tick(1, 0, 0, 0, 8'h00, 8'h00, "ce02");
    tick(1, 0, 0, 0, 8'h00, 8'h00, "ce01");
    tick(1, 0, 0, 0, 8'h00, 8'h00, "ce00_done");
    tick(0, 0, 0, 0, 8'h00, 8'h00, "done_gone");
    tick(0, 1, 0, 0, 8'h02, 8'h00, "ld0200");
    tick(0, 0, 1, 0, 8'h00, 8'h00, "start");
    tick(1, 0, 0, 0, 8'h00, 8'h00, "ce0159");
    tick(1, 0, 0, 0, 8'h00, 8'h00, "ce0158");
    tick(0, 1, 0, 0, 8'h10, 8'h00, "ld1000");
    tick(0, 0, 1, 0, 8'h00, 8'h00, "start");
    tick(1, 0, 0, 1, 8'h00, 8'h00, "stop_ce");
    tick(1, 0, 0, 0, 8'h00, 8'h00, "pause_ce");
    tick(0, 0, 1, 0, 8'h00, 8'h00, "resume");
    tick(1, 0, 0, 0, 8'h00, 8'h00, "ce0959");
    tick(0, 1, 0, 0, 8'h00, 8'h6A, "ld_bad_s");
    tick(0, 1, 0, 0, 8'h00, 8'h45, "ld0045");
    tick(0, 1, 0, 0, 8'h60, 8'h00, "ld_bad_m");
    tick(0, 1, 0, 0, 8'h0A, 8'h00, "ld_bad_m0");
    tick(0, 1, 0, 0, 8'h00, 8'h01, "ld0001");
    tick(0, 0, 1, 0, 8'h00, 8'h00, "start");
    tick(1, 0, 0, 0, 8'h00, 8'h00, "expire");
    tick(0, 0, 1, 0, 8'h00, 8'h00, "exp_start");
    tick(1, 0, 0, 0, 8'h00, 8'h00, "exp_ce");
    tick(1, 0, 1, 0, 8'h00, 8'h00, "exp_ce_st");
    tick(0, 1, 0, 0, 8'h01, 8'h00, "ld0100");
    tick(0, 0, 1, 0, 8'h00, 8'h00, "start");
    tick(1, 0, 0, 0, 8'h00, 8'h00, "ce0059");
    tick(0, 1, 0, 0, 8'h59, 8'h59, "ld5959");
    tick(0, 0, 1, 0, 8'h00, 8'h00, "start");
    tick(1, 0, 0, 0, 8'h00, 8'h00, "ce5958");
    do_reset("async_rst");
    tick(1, 0, 1, 0, 8'h00, 8'h00, "post_rst");
    for (int i = 0; i < 4000; i++) begin
      logic ld, st, sp, ce;
      logic [7:0] pm, ps;
      ld = $urandom_range(0, 99) == 0;
      st = $urandom_range(0, 9) == 0;
      sp = $urandom_range(0, 39) == 0;
      ce = $urandom_range(0, 1) == 0;
      if ($urandom_range(0, 9) == 0) begin
        pm = 8'($urandom);
        ps = 8'($urandom);
      end else begin
        pm = to_bcd($urandom_range(0, 1));
        ps = to_bcd($urandom_range(0, 59));
      end
      if ($urandom_range(0, 499) == 0) do_reset("rnd_rst");
      tick(ce, ld, st, sp, pm, ps, "rnd");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
